// File: rtl/imem_loadable.sv
// imem_loadable: instruction memory with a fetch port and a program-load port.
//
// Modes (exposed on mode): RUN (0) serves fetches, DRAIN (1) waits for a
// stalled instruction to be consumed before loading, and LOAD (2) accepts
// write requests.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   fetch_valid/fetch_addr           fetch request; fetch_ready = accepted
//   stall                            consumer cannot take instr this cycle
//   instr_valid/instr/instr_oob      fetched word, one cycle after accept
//   load_en                          request program-load mode
//   ld_valid/ld_addr/ld_data         load write; ld_ready = accepted
//   ld_count                         accepted in-range writes since reset
//   mode                             current state
module imem_loadable #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              stall,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic              instr_oob,
  input  logic              load_en,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic [1:0]        mode
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // DEPTH may equal 2**ADDR_W, so bounds are compared one bit wider.
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t state, state_nxt;

  // Storage is never reset; it starts out zeroed and only load writes change it.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic fetch_acc, ld_acc, fetch_in, ld_in, hold;

  assign fetch_in  = {1'b0, fetch_addr} < DEPTH_C;
  assign ld_in     = {1'b0, ld_addr} < DEPTH_C;
  assign hold      = instr_valid && stall;

  assign fetch_ready = (state == RUN) && !load_en && !hold;
  assign fetch_acc   = fetch_valid && fetch_ready;
  assign ld_ready    = (state == LOAD) && load_en;
  assign ld_acc      = ld_valid && ld_ready;
  assign mode        = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state. Leaving RUN/DRAIN for LOAD only happens when the output
  // stage is not held, so the fetch pipeline below clears instr_valid on
  // the same edge without any extra handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (load_en) state_nxt = hold ? DRAIN : LOAD;
      DRAIN:   if (!stall)  state_nxt = LOAD;
      LOAD:    if (!load_en) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Fetch output stage: accept -> load, valid&stall -> hold, else drop valid
  // while keeping the last word on instr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_oob   <= 1'b0;
    end else if (fetch_acc) begin
      instr_valid <= 1'b1;
      instr       <= fetch_in ? mem[fetch_addr] : '0;
      instr_oob   <= !fetch_in;
    end else if (!hold) begin
      instr_valid <= 1'b0;
    end
  end

  // Load write port; out-of-range writes are consumed and dropped.
  always_ff @(posedge clk) begin
    if (ld_acc && ld_in) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   ld_count <= '0;
    else if (ld_acc && ld_in && ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
  end

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 200;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_valid, fetch_ready, stall;
  logic [ADDR_W-1:0] fetch_addr;
  logic              instr_valid, instr_oob;
  logic [DATA_W-1:0] instr;
  logic              load_en, ld_valid, ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W:0]   ld_count;
  logic [1:0]        mode;

  int n_chk = 0;
  int n_err = 0;

  imem_loadable #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .stall(stall), .instr_valid(instr_valid), .instr(instr), .instr_oob(instr_oob),
    .load_en(load_en), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_count(ld_count), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    fetch_valid = 1'b1; fetch_addr = a;
    tick();
    fetch_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 0; fetch_addr = '0; stall = 0;
    load_en = 0; ld_valid = 0; ld_addr = '0; ld_data = '0;
    #3;
    chk("rst_mode", mode, 0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_oob", instr_oob, 0);
    chk("rst_ldcnt", ld_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First fetch after reset; memory starts zeroed
    fetch_valid = 1; fetch_addr = 8'd5;
    #1 chk("rdy_after_rst", fetch_ready, 1);
    tick();
    chk("f5_valid", instr_valid, 1);
    chk("f5_zero", instr, 0);
    fetch_valid = 0;
    tick();
    chk("idle_ivalid", instr_valid, 0);

    // Enter LOAD directly (no held instruction)
    load_en = 1;
    #1 chk("run_ld_en_frdy", fetch_ready, 0);
    tick();
    chk("load_mode", mode, 2);
    chk("load_ldrdy", ld_ready, 1);
    ld(8'd0, 32'h0C010018);
    ld(8'd1, 32'h30000003);
    chk("ldcnt_2", ld_count, 2);
    ld(8'd250, 32'hAAAA5555);
    chk("ldcnt_oob", ld_count, 2);
    ld(8'd2, 32'h11111111);
    ld(8'd2, 32'h22222222);
    chk("ldcnt_4", ld_count, 4);
    ld(8'd199, 32'hDEADBEEF);
    chk("ldcnt_edge", ld_count, 5);
    ld(8'd200, 32'h12345678);
    chk("ldcnt_depth", ld_count, 5);

    // Leave LOAD: write on the exit cycle is refused
    load_en = 0; ld_valid = 1; ld_addr = 8'd3; ld_data = 32'hFFFFFFFF;
    #1 chk("exit_ldrdy", ld_ready, 0);
    tick();
    ld_valid = 0;
    chk("exit_mode", mode, 0);
    chk("exit_ldcnt", ld_count, 5);

    // Back-to-back fetches
    fetch_valid = 1; fetch_addr = 8'd0;
    tick();
    chk("bb0", instr, 32'h0C010018);
    fetch_addr = 8'd1;
    tick();
    chk("bb1", instr, 32'h30000003);
    chk("bb1_valid", instr_valid, 1);

    // Stall holds output for 3 cycles
    stall = 1; fetch_addr = 8'd2;
    #1 chk("stall_frdy", fetch_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr, 32'h30000003);
      chk("stall_valid", instr_valid, 1);
    end
    stall = 0;
    #1 chk("unstall_frdy", fetch_ready, 1);
    tick();
    chk("last_write", instr, 32'h22222222);

    // Boundary and out-of-range fetches
    fetch_addr = 8'd199;
    tick();
    chk("f199", instr, 32'hDEADBEEF);
    chk("f199_oob", instr_oob, 0);
    fetch_addr = 8'd200;
    tick();
    chk("f200_instr", instr, 0);
    chk("f200_oob", instr_oob, 1);
    fetch_addr = 8'd250;
    tick();
    chk("f250_oob", instr_oob, 1);
    fetch_addr = 8'd3;
    tick();
    chk("f3_unwritten", instr, 0);
    fetch_addr = 8'd1;
    tick();
    fetch_valid = 0;
    tick();
    chk("idle_clr", instr_valid, 0);
    chk("idle_retain", instr, 32'h30000003);

    // DRAIN path
    fetch(8'd0);
    stall = 1; load_en = 1;
    tick();
    chk("drain_mode", mode, 1);
    chk("drain_ldrdy", ld_ready, 0);
    chk("drain_valid", instr_valid, 1);
    tick();
    chk("drain_stay", mode, 1);
    stall = 0;
    tick();
    chk("drain_load", mode, 2);
    chk("drain_clr", instr_valid, 0);

    // Reset in the middle of a load
    ld(8'd10, 32'hA0A0A0A0);
    ld(8'd11, 32'hB1B1B1B1);
    ld(8'd12, 32'hC2C2C2C2);
    chk("ldcnt_8", ld_count, 8);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_ldcnt", ld_count, 0);
    load_en = 0;
    @(posedge clk); #1;
    rst_n = 1;
    fetch_valid = 1; fetch_addr = 8'd10;
    tick();
    chk("keep10", instr, 32'hA0A0A0A0);
    fetch_addr = 8'd11;
    tick();
    chk("keep11", instr, 32'hB1B1B1B1);
    fetch_addr = 8'd12;
    tick();
    chk("keep12", instr, 32'hC2C2C2C2);
    fetch_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/imem_loadable.md
IMEM_LOADABLE -- requirements
Module: imem_loadable

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the fetch/load address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of stored words, legal range 1..2**ADDR_W.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 fetch_valid  in  1  SHALL indicate a fetch request.
REQ-007 fetch_addr  in  ADDR_W  SHALL give the word address of the request.
REQ-008 fetch_ready  out  1  SHALL indicate a fetch request is accepted this cycle.
REQ-009 stall  in  1  SHALL indicate the consumer cannot take the current instruction.
REQ-010 instr_valid  out  1  SHALL flag a valid instruction on instr.
REQ-011 instr  out  DATA_W  SHALL carry the fetched word.
REQ-012 instr_oob  out  1  SHALL flag that the fetched address was >= DEPTH.
REQ-013 load_en  in  1  SHALL request program-load mode.
REQ-014 ld_valid, ld_addr (ADDR_W), ld_data (DATA_W)  in  SHALL form the load write request.
REQ-015 ld_ready  out  1  SHALL indicate a load write is accepted this cycle.
REQ-016 ld_count  out  ADDR_W+1  SHALL count accepted in-range load writes since reset.
REQ-017 mode  out  2  SHALL expose the state: 0 RUN, 1 DRAIN, 2 LOAD.

Function
REQ-018 States SHALL be RUN, DRAIN, LOAD; fetches only in RUN, loads only in LOAD.
REQ-019 fetch_ready SHALL equal (mode==RUN) and not load_en and (not instr_valid or not stall).
REQ-020 An accepted fetch SHALL present instr_valid=1 with mem[fetch_addr] on instr exactly one cycle later (latency 1, back-to-back fetches every cycle).
REQ-021 Fetch with fetch_addr >= DEPTH SHALL return instr=0 and instr_oob=1; otherwise instr_oob=0.
REQ-022 While instr_valid and stall are both 1, instr, instr_oob and instr_valid SHALL hold unchanged.
REQ-023 When no fetch is accepted and stall=0, instr_valid SHALL clear next cycle; instr SHALL retain its last value.
REQ-024 RUN with load_en=1: next state SHALL be DRAIN if instr_valid and stall, else LOAD with instr_valid cleared.
REQ-025 DRAIN SHALL move to LOAD (clearing instr_valid) on the first cycle with stall=0, regardless of load_en.
REQ-026 ld_ready SHALL equal (mode==LOAD) and load_en.
REQ-027 An accepted write with ld_addr < DEPTH SHALL update mem[ld_addr] at that edge and increment ld_count, saturating at 2**ADDR_W.
REQ-028 An accepted write with ld_addr >= DEPTH SHALL be consumed and dropped; memory and ld_count unchanged.
REQ-029 LOAD with load_en=0 SHALL return to RUN next cycle; a write SHALL NOT be accepted that cycle.
REQ-030 Repeated writes to one address SHALL leave the last written word.
REQ-031 Memory contents SHALL be zero at time zero.

Reset
REQ-032 rst_n=0 SHALL immediately force mode=RUN, instr_valid=0, instr=0, instr_oob=0, ld_count=0, independent of clk.
REQ-033 Reset SHALL NOT alter memory contents; a load or fetch in flight at reset SHALL be abandoned, with the write landing only if its edge preceded reset assertion.
REQ-034 After rst_n deasserts, fetch_ready SHALL be asserted on the first clock edge if fetch_valid=1 and load_en=0.

Verification
REQ-035 Load: load_en=1, write 0x0C010018 @0 and 0x30000003 @1 -> ld_count=2, then RUN fetch @0,@1 back-to-back returns those words on consecutive cycles.
REQ-036 Stall: fetch @1, stall=1 for 3 cycles -> instr=0x30000003 held, fetch_ready=0; stall=0 -> next fetch accepted.
REQ-037 OOB: DEPTH=200, fetch @250 -> instr=0, instr_oob=1; load write @250 -> ld_count unchanged.
REQ-038 DRAIN: instr_valid=1, stall=1, raise load_en -> mode=1, ld_ready=0; drop stall -> mode=2, instr_valid=0.
REQ-039 Reset mid-load: assert rst_n=0 during LOAD after 3 writes -> mode=0, ld_count=0, the 3 words still readable.
